// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: sweeps enabled ALU opcodes over all operands and captures results; ALU_SEQ_CHECK_EN adds a golden-model checker
module alu_op_sequencer #(
  parameter int         SETTLE_CYCLES = 1,
  parameter logic [7:0] OP_MASK       = 8'hFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  output logic        alu_m,
  output logic        alu_s1,
  output logic        alu_s0,
  output logic [1:0]  alu_a,
  input  logic        alu_result,
  output logic        busy,
  output logic        done,
  output logic        vec_valid,
  output logic [31:0] result_vec
`ifdef ALU_SEQ_CHECK_EN
  ,
  output logic [5:0]  err_count,
  output logic        mismatch
`endif
);
  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;
  state_t state, state_n;
  logic [2:0] op, first_op, nxt_op;
  logic [1:0] a;
  logic [3:0] cnt;
  logic has_next, go, smp, settled;
  assign go = state == IDLE && start;
  assign smp = state == SAMPLE && !abort;
  assign settled = cnt == 4'(SETTLE_CYCLES - 1);
  assign busy = state == DRIVE || state == SAMPLE;
  assign done = state == DONE;
  assign {alu_m, alu_s1, alu_s0, alu_a} = busy ? {op, a} : 5'd0;
  always_comb begin
    first_op = 3'd0;
    nxt_op = 3'd0;
    has_next = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      if (OP_MASK[i]) first_op = 3'(i);
      if (OP_MASK[i] && 3'(i) > op) begin
        nxt_op = 3'(i);
        has_next = 1'b1;
      end
    end
  end
  always_comb begin
    state_n = state == IDLE ? (start ? (OP_MASK == 8'd0 ? DONE : DRIVE) : IDLE)
            : (state == DONE || abort) ? IDLE
            : state == DRIVE ? (settled ? SAMPLE : DRIVE)
            : (a != 2'd3 || has_next) ? DRIVE : DONE;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else state <= state_n;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op <= 3'd0;
      a <= 2'd0;
      cnt <= 4'd0;
      result_vec <= 32'd0;
      vec_valid <= 1'b0;
    end else begin
      cnt <= (state == DRIVE && !abort && !settled) ? cnt + 4'd1 : 4'd0;
      if (go) begin
        op <= first_op;
        a <= 2'd0;
        result_vec <= 32'd0;
        vec_valid <= 1'b0;
      end
      if (smp) begin
        result_vec[{op, a}] <= alu_result;
        a <= a + 2'd1;
        if (a == 2'd3) op <= nxt_op;
      end
      if (done) vec_valid <= 1'b1;
    end
  end
`ifdef ALU_SEQ_CHECK_EN
  logic golden, bad;
  assign golden = op[1] ? (op[0] ? ~^a : ^a) : (op[0] ? ~a[1] : a[1]);
  assign bad = smp && alu_result != golden;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_count <= 6'd0;
      mismatch <= 1'b0;
    end else begin
      mismatch <= bad;
      if (go) err_count <= 6'd0;
      else if (bad && err_count != 6'd32) err_count <= err_count + 6'd1;
    end
  end
`endif
endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: randomized self-check of alu_op_sequencer against a table-based ALU/sweep model
module tb_alu_op_sequencer;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, abort = 1'b0;
  logic [31:0] lut;
  logic m0, s10, s00, bz0, dn0, vv0, r0;
  logic m5, s15, s05, bz5, dn5, vv5, r5;
  logic mz, s1z, s0z, bzz, dnz, vvz, rz;
  logic [1:0] a0, a5, az;
  logic [31:0] rv0, rv5, rvz;
`ifdef ALU_SEQ_CHECK_EN
  logic [5:0] ec0, ec5, ecz;
  logic mm0, mm5, mmz;
`endif
  int checks = 0, errors = 0;
  int b0, b5, bz, d0, d5, dz, k0, k5, kz, bad5, mmc, kab, nd;
  logic [31:0] ideal;
  always #5 clk = ~clk;
  assign r0 = lut[{m0, s10, s00, a0}];
  assign r5 = lut[{m5, s15, s05, a5}];
  assign rz = lut[{mz, s1z, s0z, az}];
  alu_op_sequencer d_full (.clk(clk), .reset(reset), .start(start), .abort(abort),
    .alu_m(m0), .alu_s1(s10), .alu_s0(s00), .alu_a(a0), .alu_result(r0),
    .busy(bz0), .done(dn0), .vec_valid(vv0), .result_vec(rv0)
`ifdef ALU_SEQ_CHECK_EN
    , .err_count(ec0), .mismatch(mm0)
`endif
  );
  alu_op_sequencer #(.OP_MASK(8'h05)) d_m5 (.clk(clk), .reset(reset), .start(start), .abort(abort),
    .alu_m(m5), .alu_s1(s15), .alu_s0(s05), .alu_a(a5), .alu_result(r5),
    .busy(bz5), .done(dn5), .vec_valid(vv5), .result_vec(rv5)
`ifdef ALU_SEQ_CHECK_EN
    , .err_count(ec5), .mismatch(mm5)
`endif
  );
  alu_op_sequencer #(.OP_MASK(8'h00)) d_mz (.clk(clk), .reset(reset), .start(start), .abort(abort),
    .alu_m(mz), .alu_s1(s1z), .alu_s0(s0z), .alu_a(az), .alu_result(rz),
    .busy(bzz), .done(dnz), .vec_valid(vvz), .result_vec(rvz)
`ifdef ALU_SEQ_CHECK_EN
    , .err_count(ecz), .mismatch(mmz)
`endif
  );
  function automatic logic [31:0] ideal_lut();
    logic [31:0] v = '0;
    for (int op = 0; op < 8; op++)
      for (int x = 0; x < 4; x++) begin
        int a1 = x / 2, xr = (x / 2) ^ (x % 2);
        int sel = op % 4;
        int bitv = sel == 0 ? a1 : sel == 1 ? 1 - a1 : sel == 2 ? xr : 1 - xr;
        v[op * 4 + x] = bitv[0];
      end
    return v;
  endfunction
  function automatic logic [31:0] expand(input logic [7:0] mask);
    logic [31:0] e = '0;
    for (int i = 0; i < 32; i++) e[i] = mask[i / 4];
    return e;
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic sweep(input bit spam);
    b0 = 0; b5 = 0; bz = 0; d0 = 0; d5 = 0; dz = 0;
    k0 = -1; k5 = -1; kz = -1; bad5 = 0; mmc = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 80; k++) begin
      b0 += int'(bz0); b5 += int'(bz5); bz += int'(bzz);
      if (dn0) begin d0++; k0 = k; end
      if (dn5) begin d5++; k5 = k; end
      if (dnz) begin dz++; kz = k; end
      if (bz5 && {m5, s15, s05} != 3'd0 && {m5, s15, s05} != 3'd2) bad5++;
`ifdef ALU_SEQ_CHECK_EN
      mmc += int'(mm0);
`endif
      start = (spam && k >= 1 && k <= 60) ? 1'($urandom_range(0, 1)) : 1'b0;
      tick();
    end
    start = 1'b0;
  endtask
  initial begin
    ideal = ideal_lut();
    lut = ideal;
    tick();
    tick();
    chk("reset_outputs", {27'd0, m0, s10, s00, a0, bz0, dn0, vv0}, 32'd0);
    chk("reset_vec", rv0, 32'd0);
    reset = 1'b0;
    tick();
    sweep(1'b0);
    chk("full_busy_len", b0, 64);
    chk("full_done_cycle", k0, 64);
    chk("full_done_pulses", d0, 1);
    chk("full_vec", rv0, ideal);
    chk("full_vec_ideal_const", rv0, 32'h963C963C);
    chk("full_valid", vv0, 1);
    chk("m5_busy_len", b5, 16);
    chk("m5_done_cycle", k5, 16);
    chk("m5_vec", rv5, ideal & expand(8'h05));
    chk("m5_bad_opcodes", bad5, 0);
    chk("mz_busy", bz, 0);
    chk("mz_done_cycle", kz, 0);
    chk("mz_vec", rvz, 32'd0);
    chk("mz_valid", vvz, 1);
`ifdef ALU_SEQ_CHECK_EN
    chk("full_err_ideal", ec0, 0);
    chk("full_mm_ideal", mmc, 0);
`endif
    lut = 32'hFFFFFFFF;
    sweep(1'b0);
    chk("tie1_vec", rv0, 32'hFFFFFFFF);
    chk("tie1_m5_vec", rv5, expand(8'h05));
`ifdef ALU_SEQ_CHECK_EN
    chk("tie1_err", ec0, 16);
    chk("tie1_mm", mmc, 16);
`endif
    for (int r = 0; r < 3; r++) begin
      lut = $urandom;
      sweep(1'b0);
      chk("rand_vec", rv0, lut);
      chk("rand_m5_vec", rv5, lut & expand(8'h05));
`ifdef ALU_SEQ_CHECK_EN
      chk("rand_err", ec0, 32'($countones(lut ^ ideal) > 32 ? 32 : $countones(lut ^ ideal)));
`endif
    end
    lut = $urandom;
    sweep(1'b1);
    chk("spam_busy_len", b0, 64);
    chk("spam_done_cycle", k0, 64);
    chk("spam_vec", rv0, lut);
    kab = $urandom_range(2, 60);
    lut = $urandom;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (kab) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_busy", bz0, 0);
    chk("abort_valid", vv0, 0);
    chk("abort_partial", rv0, lut & 32'((64'd1 << (kab / 2)) - 64'd1));
    nd = 0;
    repeat (10) begin
      nd += int'(dn0);
      tick();
    end
    chk("abort_no_done", nd, 0);
    lut = ideal;
    sweep(1'b0);
    chk("after_abort_vec", rv0, 32'h963C963C);
    chk("after_abort_busy", b0, 64);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat ($urandom_range(3, 50)) tick();
    #2 reset = 1'b1;
    #1;
    chk("async_reset_outputs", {27'd0, m0, s10, s00, a0, bz0, dn0, vv0}, 32'd0);
    chk("async_reset_vec", rv0, 32'd0);
    tick();
    reset = 1'b0;
    tick();
    chk("post_reset_idle", {30'd0, bz0, dn0}, 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Sequential initiator for the team's 1-bit combinational ALU (mode M, select S1/S0, 2-bit operand A, 1-bit result).
- On a start request it walks every enabled opcode {M,S1,S0} over all four operand values, drives the ALU pins, and waits a settle time. It then samples the ALU result into a 32-bit result vector.
- Sits between a lab top-level (switches/buttons) and the ALU instance; used for bring-up and self-check.

Parameters:
- SETTLE_CYCLES, 1, cycles each vector is held before its sample cycle; legal range 1..15.
- OP_MASK, 8'hFF, bit n=1 enables opcode n={M,S1,S0}; disabled opcodes are skipped in zero cycles.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  run request, sampled in IDLE only.
- abort  input  1  synchronous cancel of a running sweep.
- alu_m  output  1  ALU mode bit M (opcode bit 2).
- alu_s1  output  1  ALU select S1 (opcode bit 1).
- alu_s0  output  1  ALU select S0 (opcode bit 0).
- alu_a  output  2  ALU operand A.
- alu_result  input  1  ALU combinational result.
- busy  output  1  sweep in progress.
- done  output  1  one-cycle pulse on sweep completion.
- vec_valid  output  1  result_vec holds a complete sweep.
- result_vec  output  32  captured results; bit index = {opcode[2:0], A[1:0]}.

Behaviour:
- Single clock domain; reset is asynchronous and active-high. On reset: state=IDLE, all alu_* = 0, busy=0, done=0, vec_valid=0, result_vec=0, counters=0.
- States: IDLE, DRIVE, SAMPLE, DONE.
- IDLE: alu_* driven 0. If start=1, clear result_vec and vec_valid, load the first enabled opcode with A=0, and go to DRIVE. If OP_MASK=0, go straight to DONE.
- DRIVE: busy=1; pins show the current {opcode, A}. Stay exactly SETTLE_CYCLES cycles, then go to SAMPLE.
- SAMPLE: busy=1; pins unchanged. At the end of the cycle, write alu_result into result_vec[{op,A}].
  - If A<3: increment A and go to DRIVE.
  - Otherwise: advance to the next enabled opcode with A=0 and go to DRIVE. If none remain, go to DONE.
- DONE: busy=0, done=1 for exactly one cycle, vec_valid set to 1; next state is IDLE. vec_valid holds until the next accepted start or reset.
- Timing: pins for each vector are stable for SETTLE_CYCLES+1 cycles. Busy lasts N_ops*4*(SETTLE_CYCLES+1) cycles. done is asserted in the cycle after the last SAMPLE.
- start while busy or in DONE: ignored.
- abort in DRIVE/SAMPLE: next state is IDLE, no sample that cycle, no done pulse, vec_valid stays 0, and partial result_vec is retained. abort in IDLE/DONE: ignored. If abort and start are both asserted in IDLE, start wins.
- reset mid-sweep: immediate return to reset values.
- Bits of disabled opcodes remain 0.

Optional Feature:
- Macro: ALU_SEQ_CHECK_EN.
- Defined: adds output err_count [5:0] and output mismatch [1] (one-cycle pulse).
  - In each SAMPLE, alu_result is compared against an internal golden model: op0/op4 = A1, op1/op5 = ~A1, op2/op6 = A1^A0, op3/op7 = ~(A1^A0).
  - A miscompare pulses mismatch in the cycle after SAMPLE and increments err_count (maximum 32, no wrap).
  - err_count clears on reset and on an accepted start.
- Undefined: these ports and the checker logic are absent; all other behaviour is identical.

Test Plan:
- Defaults, ideal ALU model, start pulse: busy exactly 64 cycles, done one cycle later, result_vec=32'h963C963C, vec_valid=1; with the check macro, err_count=0.
- alu_result tied 1: result_vec=32'hFFFFFFFF; with the check macro, err_count=16 and 16 mismatch pulses.
- OP_MASK=8'h05, ideal ALU: only opcodes 0 and 2 are driven, busy 16 cycles, result_vec=32'h0000060C.
- OP_MASK=8'h00: start leads to done in the next cycle, busy never 1, result_vec=0, vec_valid=1.
- abort asserted 10 cycles into a sweep: IDLE next cycle, no done, vec_valid=0. Then start again: full sweep yields 32'h963C963C.
- reset asserted mid-sweep, asynchronously between edges: all outputs 0 immediately. start pulses while busy are ignored, with busy length unchanged at 64.
